reset_sequencer: RTL and testbench



---
 rtl/reset_seq_pkg.sv | 21 ++
 rtl/seq_down_counter.sv | 31 +++
 rtl/reset_sequencer.sv | 169 ++++++++++++++++
 tb/tb_reset_sequencer.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/reset_seq_pkg.sv
// Shared types and defaults for the subsystem reset sequencer.
package reset_seq_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    DELAY    = 3'd1,
    WAIT_ACK = 3'd2,
    DONE     = 3'd3,
    ERROR    = 3'd4
  } seq_state_t;

  localparam int DEF_STAGE_DELAY = 1024;
  localparam int DEF_ACK_TIMEOUT = 1048576;
  localparam int DEF_CNT_W       = 24;

  // Width of the stage index; a single stage still needs one bit.
  function automatic int idxWidth(input int numStages);
    return (numStages > 1) ? $clog2(numStages) : 1;
  endfunction

endpackage

// File: rtl/seq_down_counter.sv
// Loadable down-counter shared by the settle-delay and ack-timeout phases.
// Saturates at zero so a stalled phase never wraps back to a large count.
module seq_down_counter
  import reset_seq_pkg::*;
#(
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             iClk,
  input  logic             iReset,
  input  logic             iLoad,
  input  logic [CNT_W-1:0] iLoadVal,
  input  logic             iEn,
  output logic             oZero
);

  logic [CNT_W-1:0] count;

  // Load has priority over decrement; decrement stops at zero.
  always_ff @(posedge iClk) begin
    if (iReset) begin
      count <= '0;
    end else if (iLoad) begin
      count <= iLoadVal;
    end else if (iEn && (count != '0)) begin
      count <= count - CNT_W'(1);
    end
  end

  assign oZero = (count == '0);

endmodule

// File: rtl/reset_sequencer.sv
// Releases subsystem resets one at a time in ascending order once the
// reset generator reports system-ready, waiting for each stage's done
// before moving on. Reports completion and ack timeouts.
module reset_sequencer
  import reset_seq_pkg::*;
#(
  parameter int NUM_STAGES  = 4,
  parameter int STAGE_DELAY = DEF_STAGE_DELAY,
  parameter int ACK_TIMEOUT = DEF_ACK_TIMEOUT,
  parameter int CNT_W       = DEF_CNT_W
) (
  input  logic                              iClk,
  input  logic                              iReset,
  input  logic                              iReset_En,
  input  logic [NUM_STAGES-1:0]             iStage_Done,
  output logic [NUM_STAGES-1:0]             oStage_Rst_n,
  output logic [idxWidth(NUM_STAGES)-1:0]   oStage_Idx,
  output logic                              oSeq_Done,
  output logic                              oSeq_Error
);

  localparam int               IDX_W        = idxWidth(NUM_STAGES);
  localparam bit               TIMEOUT_EN   = (ACK_TIMEOUT != 0);
  localparam logic [CNT_W-1:0] DELAY_LOAD   = CNT_W'(STAGE_DELAY - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LOAD = TIMEOUT_EN ? CNT_W'(ACK_TIMEOUT - 1) : '0;
  localparam logic [IDX_W-1:0] LAST_IDX     = IDX_W'(NUM_STAGES - 1);

  seq_state_t              state;
  seq_state_t              nextState;
  logic [NUM_STAGES-1:0]   nxtRst_n;
  logic [IDX_W-1:0]        nxtIdx;
  logic                    nxtDone;
  logic                    nxtError;
  logic                    cntLoad;
  logic [CNT_W-1:0]        cntLoadVal;
  logic                    cntEn;
  logic                    cntZero;
  logic                    ackSel;
  logic [NUM_STAGES-1:0]   releaseMask;
  logic                    abort;
  logic                    isLast;
  logic                    timeoutHit;

  seq_down_counter #(
    .CNT_W (CNT_W)
  ) uCounter (
    .iClk     (iClk),
    .iReset   (iReset),
    .iLoad    (cntLoad),
    .iLoadVal (cntLoadVal),
    .iEn      (cntEn),
    .oZero    (cntZero)
  );

  // Decode the current stage: its done bit and its one-hot release mask.
  // Done bits of every other stage are deliberately not looked at.
  always_comb begin
    ackSel      = 1'b0;
    releaseMask = '0;
    for (int i = 0; i < NUM_STAGES; i++) begin
      if (oStage_Idx == IDX_W'(i)) begin
        ackSel         = iStage_Done[i];
        releaseMask[i] = 1'b1;
      end
    end
    abort      = (state != IDLE) && !iReset_En;
    isLast     = (oStage_Idx == LAST_IDX);
    // An ack on the expiry edge wins, so the timeout needs the ack absent.
    timeoutHit = TIMEOUT_EN && cntZero && !ackSel;
  end

  // State register.
  always_ff @(posedge iClk) begin
    if (iReset) begin
      state <= IDLE;
    end else begin
      state <= nextState;
    end
  end

  // Next-state logic; losing system-ready aborts from any active state.
  always_comb begin
    nextState = state;
    if (abort) begin
      nextState = IDLE;
    end else begin
      case (state)
        IDLE:     if (iReset_En) nextState = DELAY;
        DELAY:    if (cntZero)   nextState = WAIT_ACK;
        WAIT_ACK: begin
          if (ackSel)          nextState = isLast ? DONE : DELAY;
          else if (timeoutHit) nextState = ERROR;
        end
        default:  nextState = state;
      endcase
    end
  end

  // Output and counter-control logic; produces next values for the
  // registered outputs so nothing reaches the ports combinationally.
  always_comb begin
    nxtRst_n   = oStage_Rst_n;
    nxtIdx     = oStage_Idx;
    nxtDone    = oSeq_Done;
    nxtError   = oSeq_Error;
    cntLoad    = 1'b0;
    cntLoadVal = DELAY_LOAD;
    cntEn      = 1'b0;
    if (abort) begin
      nxtRst_n   = '0;
      nxtIdx     = '0;
      nxtDone    = 1'b0;
      nxtError   = 1'b0;
      cntLoad    = 1'b1;
      cntLoadVal = '0;
    end else begin
      case (state)
        IDLE: begin
          if (iReset_En) begin
            nxtIdx  = '0;
            cntLoad = 1'b1;
          end
        end
        DELAY: begin
          if (cntZero) begin
            nxtRst_n   = oStage_Rst_n | releaseMask;
            cntLoad    = 1'b1;
            cntLoadVal = TIMEOUT_LOAD;
          end else begin
            cntEn = 1'b1;
          end
        end
        WAIT_ACK: begin
          if (ackSel) begin
            if (isLast) begin
              nxtDone = 1'b1;
            end else begin
              nxtIdx  = oStage_Idx + IDX_W'(1);
              cntLoad = 1'b1;
            end
          end else if (timeoutHit) begin
            nxtRst_n = '0;
            nxtError = 1'b1;
          end else begin
            cntEn = TIMEOUT_EN;
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Registered outputs.
  always_ff @(posedge iClk) begin
    if (iReset) begin
      oStage_Rst_n <= '0;
      oStage_Idx   <= '0;
      oSeq_Done    <= 1'b0;
      oSeq_Error   <= 1'b0;
    end else begin
      oStage_Rst_n <= nxtRst_n;
      oStage_Idx   <= nxtIdx;
      oSeq_Done    <= nxtDone;
      oSeq_Error   <= nxtError;
    end
  end

endmodule

// File: tb/tb_reset_sequencer.sv
// Scoreboard bench for reset_sequencer: expected output snapshots are
// queued with the edge they must appear on and checked on the falling edge.
module tb_reset_sequencer;

  localparam int NS = 3;
  localparam int SD = 8;
  localparam int AT = 32;

  logic          iClk = 1'b0;
  logic          iReset;
  logic          iReset_En;
  logic [NS-1:0] iStage_Done;
  logic [NS-1:0] oStage_Rst_n;
  logic [1:0]    oStage_Idx;
  logic          oSeq_Done;
  logic          oSeq_Error;

  logic          enB;
  logic [0:0]    doneB;
  logic [0:0]    rstB;
  logic [0:0]    idxB;
  logic          seqDoneB;
  logic          errB;

  always #5 iClk = ~iClk;

  reset_sequencer #(
    .NUM_STAGES (NS), .STAGE_DELAY (SD), .ACK_TIMEOUT (AT), .CNT_W (24)
  ) dut (
    .iClk (iClk), .iReset (iReset), .iReset_En (iReset_En),
    .iStage_Done (iStage_Done), .oStage_Rst_n (oStage_Rst_n),
    .oStage_Idx (oStage_Idx), .oSeq_Done (oSeq_Done), .oSeq_Error (oSeq_Error)
  );

  reset_sequencer #(
    .NUM_STAGES (1), .STAGE_DELAY (SD), .ACK_TIMEOUT (0), .CNT_W (24)
  ) dutNoTo (
    .iClk (iClk), .iReset (iReset), .iReset_En (enB),
    .iStage_Done (doneB), .oStage_Rst_n (rstB),
    .oStage_Idx (idxB), .oSeq_Done (seqDoneB), .oSeq_Error (errB)
  );

  typedef struct {
    int         edgeN;
    bit         dutB;
    logic [7:0] rst;
    logic [3:0] idx;
    bit         careIdx;
    logic       done;
    logic       err;
    string      tag;
  } exp_t;

  exp_t sbQ[$];
  int   edgeNum   = 0;
  int   nCompared = 0;
  int   nMismatch = 0;

  always @(posedge iClk) edgeNum <= edgeNum + 1;

  task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    nCompared++;
    if (obs !== expv) begin
      nMismatch++;
      $display("FAIL %s: observed %h expected %h (edge %0d)", tag, obs, expv, edgeNum);
    end
  endtask

  task automatic expectAt(input int e, input bit b, input logic [7:0] r, input logic [3:0] ix,
                          input bit ci, input logic d, input logic er, input string tag);
    exp_t x;
    x.edgeN = e; x.dutB = b; x.rst = r; x.idx = ix;
    x.careIdx = ci; x.done = d; x.err = er; x.tag = tag;
    sbQ.push_back(x);
  endtask

  task automatic ea(input int e, input logic [2:0] r, input logic [1:0] ix,
                    input logic d, input logic er, input string tag);
    expectAt(e, 1'b0, {5'd0, r}, {2'd0, ix}, 1'b1, d, er, tag);
  endtask

  task automatic eaNoIdx(input int e, input logic [2:0] r, input logic d,
                         input logic er, input string tag);
    expectAt(e, 1'b0, {5'd0, r}, 4'd0, 1'b0, d, er, tag);
  endtask

  task automatic runTo(input int e);
    while (edgeNum < e) begin
      @(posedge iClk);
      #1;
    end
  endtask

  // Falling-edge monitor: pop every expectation due at this edge.
  always @(negedge iClk) begin
    exp_t        x;
    logic [31:0] ob;
    logic [31:0] ex;
    while (sbQ.size() > 0 && sbQ[0].edgeN <= edgeNum) begin
      x = sbQ.pop_front();
      if (x.edgeN < edgeNum) begin
        checkVal({x.tag, "_late"}, 32'(edgeNum), 32'(x.edgeN));
      end else begin
        if (x.dutB)
          ob = {16'd0, 7'd0, rstB, 3'd0, idxB, 2'd0, seqDoneB, errB};
        else
          ob = {16'd0, 5'd0, oStage_Rst_n, 2'd0, oStage_Idx, 2'd0, oSeq_Done, oSeq_Error};
        ex = {16'd0, x.rst, x.idx, 2'd0, x.done, x.err};
        if (!x.careIdx) begin
          ob[7:4] = 4'd0;
          ex[7:4] = 4'd0;
        end
        checkVal(x.tag, ob, ex);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish (edge %0d)", edgeNum);
    $fatal(1);
  end

  initial begin
    int b;
    int b2;
    iReset = 1'b1; iReset_En = 1'b0; iStage_Done = '0; enB = 1'b0; doneB = 1'b0;

    // Reset state
    ea(1, 3'b000, 2'd0, 1'b0, 1'b0, "rst_a");
    expectAt(1, 1'b1, 8'd0, 4'd0, 1'b1, 1'b0, 1'b0, "rst_b");
    ea(4, 3'b000, 2'd0, 1'b0, 1'b0, "idle_a");
    runTo(2);
    iReset = 1'b0;
    runTo(5);

    // Nominal sequence, dones returned 3 cycles after each release
    b = edgeNum + 1;
    iReset_En = 1'b1;
    ea(b,      3'b000, 2'd0, 1'b0, 1'b0, "t1_start");
    ea(b + 7,  3'b000, 2'd0, 1'b0, 1'b0, "t1_pre0");
    ea(b + 8,  3'b001, 2'd0, 1'b0, 1'b0, "t1_rel0");
    ea(b + 10, 3'b001, 2'd0, 1'b0, 1'b0, "t1_wait0");
    ea(b + 11, 3'b001, 2'd1, 1'b0, 1'b0, "t1_ack0");
    ea(b + 18, 3'b001, 2'd1, 1'b0, 1'b0, "t1_pre1");
    ea(b + 19, 3'b011, 2'd1, 1'b0, 1'b0, "t1_rel1");
    ea(b + 22, 3'b011, 2'd2, 1'b0, 1'b0, "t1_ack1");
    ea(b + 29, 3'b011, 2'd2, 1'b0, 1'b0, "t1_pre2");
    ea(b + 30, 3'b111, 2'd2, 1'b0, 1'b0, "t1_rel2");
    ea(b + 32, 3'b111, 2'd2, 1'b0, 1'b0, "t1_wait2");
    ea(b + 33, 3'b111, 2'd2, 1'b1, 1'b0, "t1_done");
    ea(b + 41, 3'b111, 2'd2, 1'b1, 1'b0, "t1_hold");
    ea(b + 42, 3'b000, 2'd0, 1'b0, 1'b0, "t1_abort");
    runTo(b + 10); iStage_Done[0] = 1'b1;
    runTo(b + 21); iStage_Done[1] = 1'b1;
    runTo(b + 32); iStage_Done[2] = 1'b1;
    runTo(b + 38); iStage_Done = '0;
    runTo(b + 41); iReset_En = 1'b0;
    runTo(b + 43);

    // Ack timeout on stage 1, with unrelated done bits moving meanwhile
    b = edgeNum + 1;
    iReset_En = 1'b1;
    ea(b + 8,  3'b001, 2'd0, 1'b0, 1'b0, "t2_rel0");
    ea(b + 19, 3'b011, 2'd1, 1'b0, 1'b0, "t2_rel1");
    ea(b + 50, 3'b011, 2'd1, 1'b0, 1'b0, "t2_preexp");
    eaNoIdx(b + 51, 3'b000, 1'b0, 1'b1, "t2_err");
    eaNoIdx(b + 60, 3'b000, 1'b0, 1'b1, "t2_errhold");
    ea(b + 61, 3'b000, 2'd0, 1'b0, 1'b0, "t2_clear");
    runTo(b + 10); iStage_Done[0] = 1'b1;
    runTo(b + 25); iStage_Done[2] = 1'b1;
    runTo(b + 27); iStage_Done[2] = 1'b0;
    runTo(b + 60); iReset_En = 1'b0;
    runTo(b + 62);

    // Abort in stage 1 WAIT_ACK, restart; done pre-asserted; ack on expiry edge
    b = edgeNum + 1;
    iReset_En = 1'b1;
    ea(b + 8,  3'b001, 2'd0, 1'b0, 1'b0, "t3_rel0");
    ea(b + 9,  3'b001, 2'd1, 1'b0, 1'b0, "t3_preack0");
    ea(b + 17, 3'b011, 2'd1, 1'b0, 1'b0, "t3_rel1");
    ea(b + 20, 3'b000, 2'd0, 1'b0, 1'b0, "t3_abort");
    runTo(b + 19); iReset_En = 1'b0;
    runTo(b + 21); iReset_En = 1'b1; iStage_Done[1] = 1'b1;
    b2 = b + 22;
    ea(b2 + 7,  3'b000, 2'd0, 1'b0, 1'b0, "t3_pre0");
    ea(b2 + 8,  3'b001, 2'd0, 1'b0, 1'b0, "t3_rerel0");
    ea(b2 + 9,  3'b001, 2'd1, 1'b0, 1'b0, "t3_reack0");
    ea(b2 + 17, 3'b011, 2'd1, 1'b0, 1'b0, "t3_rerel1");
    ea(b2 + 18, 3'b011, 2'd2, 1'b0, 1'b0, "t3_preack1");
    ea(b2 + 26, 3'b111, 2'd2, 1'b0, 1'b0, "t3_rerel2");
    ea(b2 + 57, 3'b111, 2'd2, 1'b0, 1'b0, "t5_preexp");
    ea(b2 + 58, 3'b111, 2'd2, 1'b1, 1'b0, "t5_ackonexp");
    ea(b2 + 61, 3'b111, 2'd2, 1'b1, 1'b0, "t5_noerr");
    runTo(b2 + 57); iStage_Done[2] = 1'b1;
    runTo(b2 + 61);

    // Synchronous reset while in DONE, system-ready still high
    b = edgeNum + 1;
    iReset = 1'b1;
    ea(b,      3'b000, 2'd0, 1'b0, 1'b0, "t4_rstdone");
    ea(b + 2,  3'b000, 2'd0, 1'b0, 1'b0, "t4_rstheld");
    ea(b + 14, 3'b000, 2'd0, 1'b0, 1'b0, "t4_quiet");
    runTo(b + 2); iReset = 1'b0; iReset_En = 1'b0; iStage_Done = '0;
    runTo(b + 14);

    // Synchronous reset mid-DELAY; held past the would-be release edge
    b = edgeNum + 1;
    iReset_En = 1'b1;
    ea(b + 4,  3'b000, 2'd0, 1'b0, 1'b0, "t4_delay");
    ea(b + 5,  3'b000, 2'd0, 1'b0, 1'b0, "t4_rstdelay");
    ea(b + 10, 3'b000, 2'd0, 1'b0, 1'b0, "t4_norel");
    ea(b + 24, 3'b000, 2'd0, 1'b0, 1'b0, "t4_stillidle");
    runTo(b + 4); iReset = 1'b1;
    runTo(b + 12); iReset = 1'b0; iReset_En = 1'b0;
    runTo(b + 24);

    // Timeout disabled: ack 10000 cycles after release raises no error
    b = edgeNum + 1;
    enB = 1'b1;
    expectAt(b + 7,     1'b1, 8'd0, 4'd0, 1'b1, 1'b0, 1'b0, "t5b_pre0");
    expectAt(b + 8,     1'b1, 8'd1, 4'd0, 1'b1, 1'b0, 1'b0, "t5b_rel0");
    expectAt(b + 5008,  1'b1, 8'd1, 4'd0, 1'b1, 1'b0, 1'b0, "t5b_mid");
    expectAt(b + 10007, 1'b1, 8'd1, 4'd0, 1'b1, 1'b0, 1'b0, "t5b_preack");
    expectAt(b + 10008, 1'b1, 8'd1, 4'd0, 1'b1, 1'b1, 1'b0, "t5b_done");
    runTo(b + 10007); doneB = 1'b1;
    runTo(b + 10011);

    checkVal("sb_drained", 32'(sbQ.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatch);
    $finish;
  end

endmodule
